// File: rtl/trap_controller_pkg.sv
// ============================================================================
//  Module      : trap_controller_pkg
//  Description : Shared constants and decode helper for the trap controller:
//                privilege encodings, EXCOp encodings, SYSTEM sub-decode
//                constants, exception cause codes and FSM state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_controller_pkg;

    // Privilege levels
    localparam logic [1:0] c_priv_m = 2'b11;
    localparam logic [1:0] c_priv_u = 2'b00;

    // EXCOp encodings from the decoder
    localparam logic [1:0] c_excop_none    = 2'b00;
    localparam logic [1:0] c_excop_system  = 2'b01;
    localparam logic [1:0] c_excop_illegal = 2'b10;
    localparam logic [1:0] c_excop_rsvd    = 2'b11;

    // SYSTEM sub-decode
    localparam logic [2:0]  c_funct3_priv   = 3'b000;
    localparam logic [11:0] c_funct12_ecall = 12'h000;
    localparam logic [11:0] c_funct12_mret  = 12'h302;

    // Synchronous exception cause codes
    localparam int unsigned c_cause_illegal = 2;
    localparam int unsigned c_cause_ecall_u = 8;
    localparam int unsigned c_cause_ecall_m = 11;

    // FSM state encodings
    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_enter  = 2'd1;
    localparam logic [1:0] c_st_return = 2'd2;

    // Classification of the slot instruction
    typedef enum logic [1:0] {
        DEC_NONE    = 2'd0,
        DEC_ECALL   = 2'd1,
        DEC_MRET    = 2'd2,
        DEC_ILLEGAL = 2'd3
    } decode_t;

    // mret outside M-mode is illegal; EXCOp 11 is treated as illegal.
    function automatic decode_t decode_insn(
        input logic [1:0]  excop,
        input logic [2:0]  funct3,
        input logic [11:0] funct12,
        input logic [1:0]  priv
    );
        decode_t d;
        d = DEC_NONE;
        case (excop)
            c_excop_none: d = DEC_NONE;
            c_excop_system: begin
                if (funct3 == c_funct3_priv && funct12 == c_funct12_ecall)
                    d = DEC_ECALL;
                else if (funct3 == c_funct3_priv && funct12 == c_funct12_mret)
                    d = (priv == c_priv_m) ? DEC_MRET : DEC_ILLEGAL;
                else
                    d = DEC_ILLEGAL;
            end
            default: d = DEC_ILLEGAL;
        endcase
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_controller_irq_pending.sv
// ============================================================================
//  Module      : trap_controller_irq_pending
//  Description : Interrupt pending tracker. Detects rising edges on level
//                interrupt lines, latches them into pending bits, qualifies
//                with per-channel mask and global enable, and selects the
//                lowest eligible channel.
//  Ports       : i_clk, i_rst_n       clock / sync active-low reset
//                i_irq, i_irq_mask    interrupt lines and channel enables
//                i_global_en          privilege/mie gate
//                i_take, i_take_idx   clear pending bit of the taken channel
//                o_pend               pending bits
//                o_valid, o_idx       winning eligible channel
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_controller_irq_pending #(
    parameter int NUM_IRQ = 4,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_mask,
    input  logic               i_global_en,
    input  logic               i_take,
    input  logic [IDX_W-1:0]   i_take_idx,
    output logic [NUM_IRQ-1:0] o_pend,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pend;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_clr;
    logic [NUM_IRQ-1:0] w_elig;

    assign w_rise = i_irq & ~r_irq_q;
    assign w_clr  = i_take ? (NUM_IRQ'(1) << i_take_idx) : '0;
    assign w_elig = r_pend & i_irq_mask & {NUM_IRQ{i_global_en}};

    // A fresh edge arriving in the same cycle its channel is taken is a new
    // event, so the set term wins over the clear.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_irq_q <= '0;
            r_pend  <= '0;
        end else begin
            r_irq_q <= i_irq;
            r_pend  <= (r_pend & ~w_clr) | w_rise;
        end
    end

    // Descending scan so the lowest eligible index is the last assignment.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (w_elig[k]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(k);
            end
        end
    end

    assign o_pend = r_pend;

endmodule

`default_nettype wire

// File: rtl/trap_controller.sv
// ============================================================================
//  Module      : trap_controller
//  Description : Machine-mode trap controller. Accepts ecall / illegal
//                exceptions, mret and external interrupts from the slot
//                instruction, updates mepc/mcause/mstatus state and issues a
//                one-cycle pipeline redirect.
//  Config      : TRAP_VECTORED_EN - when defined, interrupts redirect to
//                mtvec base + 4*cause; otherwise every trap goes to base.
//  Ports       : i_clk, i_rst_n            clock / sync active-low reset
//                i_valid, i_EXCOp,
//                i_funct3, i_funct12, i_pc slot instruction information
//                i_mtvec                   trap vector base
//                i_irq, i_irq_mask         interrupt lines / enables
//                o_busy, o_redirect,
//                o_redirect_pc             pipeline control
//                o_mcause, o_mepc,
//                o_priv_mode, o_mie, o_mpie architectural state
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_controller
    import trap_controller_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int NUM_IRQ        = 4,
    parameter int IRQ_CAUSE_BASE = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    input  logic [1:0]         i_EXCOp,
    input  logic [2:0]         i_funct3,
    input  logic [11:0]        i_funct12,
    input  logic [XLEN-1:0]    i_pc,
    input  logic [XLEN-1:0]    i_mtvec,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_irq_mask,
    output logic               o_busy,
    output logic               o_redirect,
    output logic [XLEN-1:0]    o_redirect_pc,
    output logic [XLEN-1:0]    o_mcause,
    output logic [XLEN-1:0]    o_mepc,
    output logic [1:0]         o_priv_mode,
    output logic               o_mie,
    output logic               o_mpie
);

    localparam int c_idx_w = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [1:0]         r_priv;
    logic [1:0]         r_mpp;
    logic               r_mie;
    logic               r_mpie;
    logic [XLEN-1:0]    r_mcause;
    logic [XLEN-1:0]    r_mepc;

    decode_t            w_dec;
    logic               w_accept;
    logic               w_global_en;
    logic               w_irq_valid;
    logic [c_idx_w-1:0] w_irq_idx;
    logic [NUM_IRQ-1:0] w_pend;
    logic               w_take_irq;
    logic               w_take_exc;
    logic               w_take_mret;
    logic [XLEN-1:0]    w_exc_cause;
    logic [XLEN-1:0]    w_irq_cause;
    logic [XLEN-1:0]    w_mtvec_base;
    logic [XLEN-1:0]    w_trap_target;

    // ------------------------------------------------------------------
    // Interrupt pending / selection
    // ------------------------------------------------------------------
    assign w_global_en = (r_priv == c_priv_u) | r_mie;

    trap_controller_irq_pending #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (c_idx_w)
    ) u_irq_pending (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_irq       (i_irq),
        .i_irq_mask  (i_irq_mask),
        .i_global_en (w_global_en),
        .i_take      (w_take_irq),
        .i_take_idx  (w_irq_idx),
        .o_pend      (w_pend),
        .o_valid     (w_irq_valid),
        .o_idx       (w_irq_idx)
    );

    // ------------------------------------------------------------------
    // Decode and accept. An eligible interrupt pre-empts the slot
    // instruction, which is then not executed.
    // ------------------------------------------------------------------
    assign w_dec       = decode_insn(i_EXCOp, i_funct3, i_funct12, r_priv);
    assign w_accept    = (r_state == c_st_idle) & i_valid;
    assign w_take_irq  = w_accept & w_irq_valid;
    assign w_take_exc  = w_accept & ~w_irq_valid &
                         ((w_dec == DEC_ECALL) | (w_dec == DEC_ILLEGAL));
    assign w_take_mret = w_accept & ~w_irq_valid & (w_dec == DEC_MRET);

    always_comb begin
        w_exc_cause = XLEN'(c_cause_illegal);
        if (w_dec == DEC_ECALL)
            w_exc_cause = (r_priv == c_priv_m) ? XLEN'(c_cause_ecall_m)
                                               : XLEN'(c_cause_ecall_u);
    end

    assign w_irq_cause = {1'b1, (XLEN-1)'(IRQ_CAUSE_BASE) + (XLEN-1)'(w_irq_idx)};

    // ------------------------------------------------------------------
    // Redirect target
    // ------------------------------------------------------------------
    assign w_mtvec_base = {i_mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
    assign w_trap_target = r_mcause[XLEN-1]
                         ? w_mtvec_base + {r_mcause[XLEN-3:0], 2'b00}
                         : w_mtvec_base;
`else
    assign w_trap_target = w_mtvec_base;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= c_st_idle;
        else
            r_state <= w_next_state;
    end

    // FSM: next state
    always_comb begin
        w_next_state = c_st_idle;
        case (r_state)
            c_st_idle: begin
                if (w_take_irq | w_take_exc)
                    w_next_state = c_st_enter;
                else if (w_take_mret)
                    w_next_state = c_st_return;
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        o_busy        = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = w_trap_target;
        case (r_state)
            c_st_enter: begin
                o_busy     = 1'b1;
                o_redirect = 1'b1;
            end
            c_st_return: begin
                o_busy        = 1'b1;
                o_redirect    = 1'b1;
                o_redirect_pc = r_mepc;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Architectural trap state
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_priv   <= c_priv_m;
            r_mpp    <= c_priv_u;
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mcause <= '0;
            r_mepc   <= '0;
        end else if (w_take_irq | w_take_exc) begin
            r_mepc   <= i_pc;
            r_mcause <= w_take_irq ? w_irq_cause : w_exc_cause;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
            r_mpp    <= r_priv;
            r_priv   <= c_priv_m;
        end else if (w_take_mret) begin
            r_priv   <= r_mpp;
            r_mie    <= r_mpie;
            r_mpie   <= 1'b1;
            r_mpp    <= c_priv_u;
        end
    end

    assign o_mcause    = r_mcause;
    assign o_mepc      = r_mepc;
    assign o_priv_mode = r_priv;
    assign o_mie       = r_mie;
    assign o_mpie      = r_mpie;

endmodule

`default_nettype wire

// File: tb/tb_trap_controller.sv
// ============================================================================
//  Module      : tb_trap_controller
//  Description : Directed self-checking bench for trap_controller.
//                Expected values are hand-computed for XLEN=32, NUM_IRQ=4,
//                IRQ_CAUSE_BASE=16. Honours TRAP_VECTORED_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trap_controller;

`ifdef TRAP_VECTORED_EN
    localparam logic [31:0] c_exp_irq0 = 32'h0000_0840;
    localparam logic [31:0] c_exp_irq1 = 32'h0000_0844;
    localparam logic [31:0] c_exp_irq2 = 32'h0000_0848;
`else
    localparam logic [31:0] c_exp_irq0 = 32'h0000_0800;
    localparam logic [31:0] c_exp_irq1 = 32'h0000_0800;
    localparam logic [31:0] c_exp_irq2 = 32'h0000_0800;
`endif

    logic        r_clk;
    logic        r_rst_n;
    logic        r_valid;
    logic [1:0]  r_excop;
    logic [2:0]  r_funct3;
    logic [11:0] r_funct12;
    logic [31:0] r_pc;
    logic [31:0] r_mtvec;
    logic [3:0]  r_irq;
    logic [3:0]  r_irq_mask;

    logic        w_busy;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_mcause;
    logic [31:0] w_mepc;
    logic [1:0]  w_priv;
    logic        w_mie;
    logic        w_mpie;

    int n_tests = 0;
    int n_fail  = 0;

    trap_controller #(
        .XLEN           (32),
        .NUM_IRQ        (4),
        .IRQ_CAUSE_BASE (16)
    ) dut (
        .i_clk         (r_clk),
        .i_rst_n       (r_rst_n),
        .i_valid       (r_valid),
        .i_EXCOp       (r_excop),
        .i_funct3      (r_funct3),
        .i_funct12     (r_funct12),
        .i_pc          (r_pc),
        .i_mtvec       (r_mtvec),
        .i_irq         (r_irq),
        .i_irq_mask    (r_irq_mask),
        .o_busy        (w_busy),
        .o_redirect    (w_redirect),
        .o_redirect_pc (w_redirect_pc),
        .o_mcause      (w_mcause),
        .o_mepc        (w_mepc),
        .o_priv_mode   (w_priv),
        .o_mie         (w_mie),
        .o_mpie        (w_mpie)
    );

    initial r_clk = 1'b0;
    always #5 r_clk = ~r_clk;

    task automatic step();
        @(posedge r_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] excop, input logic [2:0] f3,
                         input logic [11:0] f12, input logic [31:0] pc);
        r_valid   = 1'b1;
        r_excop   = excop;
        r_funct3  = f3;
        r_funct12 = f12;
        r_pc      = pc;
    endtask

    task automatic idle_slot();
        r_valid = 1'b0;
        r_excop = 2'b00;
    endtask

    initial begin
        r_rst_n    = 1'b0;
        r_valid    = 1'b0;
        r_excop    = 2'b00;
        r_funct3   = 3'b000;
        r_funct12  = 12'h000;
        r_pc       = 32'h0;
        r_mtvec    = 32'h0000_0800;
        r_irq      = 4'b0000;
        r_irq_mask = 4'b0000;
        step();
        step();

        // Reset state
        check("rst_busy",   32'(w_busy),     32'd0);
        check("rst_redir",  32'(w_redirect), 32'd0);
        check("rst_priv",   32'(w_priv),     32'd3);
        check("rst_mie",    32'(w_mie),      32'd0);
        check("rst_mpie",   32'(w_mpie),     32'd0);
        check("rst_mcause", w_mcause,        32'd0);
        check("rst_mepc",   w_mepc,          32'd0);

        // mret from M after reset drops to U (MPP=U), returns to mepc=0
        r_rst_n = 1'b1;
        issue(2'b01, 3'b000, 12'h302, 32'h50);
        step();
        check("mret0_redir",  32'(w_redirect), 32'd1);
        check("mret0_pc",     w_redirect_pc,   32'h0);
        check("mret0_busy",   32'(w_busy),     32'd1);
        check("mret0_priv",   32'(w_priv),     32'd0);
        check("mret0_mie",    32'(w_mie),      32'd0);
        check("mret0_mpie",   32'(w_mpie),     32'd1);
        // valid stays high during RETURN and must be ignored
        step();
        idle_slot();
        check("busy_ign_redir",  32'(w_redirect), 32'd0);
        check("busy_ign_busy",   32'(w_busy),     32'd0);
        check("busy_ign_priv",   32'(w_priv),     32'd0);
        check("busy_ign_mcause", w_mcause,        32'd0);

        // U-mode ecall at 0x100
        issue(2'b01, 3'b000, 12'h000, 32'h100);
        step();
        idle_slot();
        check("ecallu_redir",  32'(w_redirect), 32'd1);
        check("ecallu_pc",     w_redirect_pc,   32'h800);
        check("ecallu_mcause", w_mcause,        32'd8);
        check("ecallu_mepc",   w_mepc,          32'h100);
        check("ecallu_priv",   32'(w_priv),     32'd3);
        check("ecallu_mpie",   32'(w_mpie),     32'd0);
        step();
        check("ecallu_pulse_end", 32'(w_redirect), 32'd0);
        check("ecallu_idle",      32'(w_busy),     32'd0);

        // mret back to U at 0x100
        issue(2'b01, 3'b000, 12'h302, 32'h180);
        step();
        idle_slot();
        check("mret1_pc",   w_redirect_pc,   32'h100);
        check("mret1_priv", 32'(w_priv),     32'd0);
        check("mret1_mpie", 32'(w_mpie),     32'd1);
        step();

        // mret in U-mode is illegal
        issue(2'b01, 3'b000, 12'h302, 32'h104);
        step();
        idle_slot();
        check("umret_redir",  32'(w_redirect), 32'd1);
        check("umret_pc",     w_redirect_pc,   32'h800);
        check("umret_mcause", w_mcause,        32'd2);
        check("umret_mepc",   w_mepc,          32'h104);
        check("umret_priv",   32'(w_priv),     32'd3);
        check("umret_mpie",   32'(w_mpie),     32'd1 ^ 32'd1);
        step();

        // mret with mepc 0x104, MPP=U
        issue(2'b01, 3'b000, 12'h302, 32'h10c);
        step();
        idle_slot();
        check("mret2_pc",   w_redirect_pc, 32'h104);
        check("mret2_priv", 32'(w_priv),   32'd0);
        check("mret2_mie",  32'(w_mie),    32'd0);
        check("mret2_mpie", 32'(w_mpie),   32'd1);
        step();

        // Interrupts: edges latch, nothing taken without valid
        r_irq      = 4'b0110;
        r_irq_mask = 4'b1111;
        step();
        check("novalid_busy1", 32'(w_busy), 32'd0);
        step();
        check("novalid_busy2", 32'(w_busy), 32'd0);
        check("pend_0110",     32'(dut.u_irq_pending.r_pend), 32'h6);

        // Valid ecall pre-empted by channel 1
        issue(2'b01, 3'b000, 12'h000, 32'h200);
        step();
        idle_slot();
        check("irq1_redir",  32'(w_redirect), 32'd1);
        check("irq1_pc",     w_redirect_pc,   c_exp_irq1);
        check("irq1_mcause", w_mcause,        32'h8000_0011);
        check("irq1_mepc",   w_mepc,          32'h200);
        check("irq1_priv",   32'(w_priv),     32'd3);
        check("irq1_pend",   32'(dut.u_irq_pending.r_pend), 32'h4);
        step();

        // M-mode with mie=0: channel 2 blocked; held level does not re-set ch1
        issue(2'b00, 3'b000, 12'h000, 32'h208);
        step();
        idle_slot();
        check("mblock_busy", 32'(w_busy), 32'd0);
        check("mblock_pend", 32'(dut.u_irq_pending.r_pend), 32'h4);

        // Return to U, then channel 2 is taken
        issue(2'b01, 3'b000, 12'h302, 32'h20c);
        step();
        idle_slot();
        check("mret3_pc", w_redirect_pc, 32'h200);
        step();
        issue(2'b00, 3'b000, 12'h000, 32'h300);
        step();
        idle_slot();
        check("irq2_pc",     w_redirect_pc, c_exp_irq2);
        check("irq2_mcause", w_mcause,      32'h8000_0012);
        check("irq2_mepc",   w_mepc,        32'h300);
        check("irq2_pend",   32'(dut.u_irq_pending.r_pend), 32'h0);
        step();

        // M-mode ecall -> cause 11, MPP=M
        issue(2'b01, 3'b000, 12'h000, 32'h400);
        step();
        idle_slot();
        check("ecallm_mcause", w_mcause,      32'd11);
        check("ecallm_mepc",   w_mepc,        32'h400);
        check("ecallm_pc",     w_redirect_pc, 32'h800);
        step();
        issue(2'b01, 3'b000, 12'h302, 32'h410);
        step();
        idle_slot();
        check("mretm_pc",   w_redirect_pc, 32'h400);
        check("mretm_priv", 32'(w_priv),   32'd3);
        step();

        // Reserved EXCOp and non-priv SYSTEM are illegal
        issue(2'b11, 3'b000, 12'h000, 32'h404);
        step();
        idle_slot();
        check("rsvd_mcause", w_mcause, 32'd2);
        check("rsvd_mepc",   w_mepc,   32'h404);
        step();
        issue(2'b01, 3'b001, 12'h000, 32'h408);
        step();
        idle_slot();
        check("csr_mcause", w_mcause, 32'd2);
        check("csr_mepc",   w_mepc,   32'h408);
        step();

        // Reset during ENTER aborts the redirect
        issue(2'b01, 3'b000, 12'h000, 32'h500);
        step();
        idle_slot();
        check("pre_rst_redir", 32'(w_redirect), 32'd1);
        r_rst_n = 1'b0;
        r_irq   = 4'b0000;
        step();
        check("abort_redir",  32'(w_redirect), 32'd0);
        check("abort_busy",   32'(w_busy),     32'd0);
        check("abort_mcause", w_mcause,        32'd0);
        check("abort_priv",   32'(w_priv),     32'd3);
        r_rst_n = 1'b1;
        step();
        check("abort_no_pulse", 32'(w_redirect), 32'd0);

        // Drop to U, channel 0 masked then unmasked; mtvec low bits ignored
        issue(2'b01, 3'b000, 12'h302, 32'h10);
        step();
        idle_slot();
        step();
        r_irq      = 4'b0001;
        r_irq_mask = 4'b0000;
        r_mtvec    = 32'h0000_0803;
        step();
        issue(2'b00, 3'b000, 12'h000, 32'h5f0);
        step();
        idle_slot();
        check("masked_busy", 32'(w_busy), 32'd0);
        r_irq_mask = 4'b0001;
        issue(2'b00, 3'b000, 12'h000, 32'h600);
        step();
        idle_slot();
        check("irq0_redir",  32'(w_redirect), 32'd1);
        check("irq0_pc",     w_redirect_pc,   c_exp_irq0);
        check("irq0_mcause", w_mcause,        32'h8000_0010);
        check("irq0_mepc",   w_mepc,          32'h600);
        step();
        check("irq0_idle", 32'(w_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
